// File: rtl/result_write_monitor_pkg.sv
// Shared types and width helpers for the result write monitor.
// Width helpers are functions so each instance can derive widths from its own MAT_SIZE_BITS.
package mon_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } mon_state_t;

  localparam int unsigned DEF_MAT_SIZE_BITS = 4;

  // Width of M*K and of the write counter.
  function automatic int unsigned cnt_w(input int unsigned mat_size_bits);
    return 2 * mat_size_bits;
  endfunction

  localparam int unsigned DEF_CNT_W = cnt_w(DEF_MAT_SIZE_BITS);

endpackage

// File: rtl/result_write_monitor_if.sv
// Snooped core output-BRAM write port plus the job start/done strobes.
interface result_write_monitor_if #(
  parameter int unsigned MAT_SIZE_BITS = 4,
  parameter int unsigned BRAM_DEPTH    = 10,
  parameter int unsigned VAL_SIZE      = 24
);
  logic                     start;
  logic [MAT_SIZE_BITS-1:0] M;
  logic [MAT_SIZE_BITS-1:0] K;
  logic [BRAM_DEPTH-1:0]    base_addr_out;
  logic                     w_out;
  logic [BRAM_DEPTH-1:0]    add_out;
  logic [VAL_SIZE-1:0]      din_mem_out;
  logic                     done;

  modport master (
    output start, M, K, base_addr_out, w_out, add_out, din_mem_out, done
  );

  modport slave (
    input start, M, K, base_addr_out, w_out, add_out, din_mem_out, done
  );
endinterface

// File: rtl/result_write_monitor_addr_range_check.sv
// Combinational check that addr lies in [base, base+exp); the end is computed
// without wrap so ranges running past the top of the BRAM still reject correctly.
module addr_range_check #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned EXP_W  = 8
) (
  input  logic [ADDR_W-1:0] base,
  input  logic [EXP_W-1:0]  exp,
  input  logic [ADDR_W-1:0] addr,
  output logic              out_of_range
);
  localparam int unsigned EXT_W = ((ADDR_W > EXP_W) ? ADDR_W : EXP_W) + 1;

  logic [EXT_W-1:0] lo;
  logic [EXT_W-1:0] hi;
  logic [EXT_W-1:0] a;

  always_comb begin
    lo           = EXT_W'(base);
    hi           = lo + EXT_W'(exp);
    a            = EXT_W'(addr);
    out_of_range = (a < lo) || (a >= hi);
  end
endmodule

// File: rtl/result_write_monitor.sv
// Snoops the matmul core's output-BRAM writes per job: counts, range-checks,
// checksums and times them, then holds a status record for debug probes.
module result_write_monitor
  import mon_pkg::*;
#(
  parameter int unsigned MAT_SIZE_BITS  = 4,
  parameter int unsigned BRAM_DEPTH     = 10,
  parameter int unsigned VAL_SIZE       = 24,
  parameter int unsigned CYC_W          = 24,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                       clk,
  input  logic                       rst,
  result_write_monitor_if.slave      wr,
  output logic                       busy,
  output logic                       result_valid,
  output logic [2*MAT_SIZE_BITS-1:0] write_count,
  output logic [VAL_SIZE-1:0]        checksum,
  output logic [CYC_W-1:0]           cycle_count,
  output logic                       addr_err,
  output logic                       count_err,
  output logic                       stray_err,
  output logic                       timeout
);
  localparam int unsigned CNT_W = cnt_w(MAT_SIZE_BITS);

  mon_state_t            state_q, state_d;
  logic [CNT_W-1:0]      exp_q, exp_d;
  logic [BRAM_DEPTH-1:0] base_q, base_d;
  logic [CNT_W-1:0]      wc_q, wc_d;
  logic [VAL_SIZE-1:0]   cs_q, cs_d;
  logic [CYC_W-1:0]      cyc_q, cyc_d;
  logic                  ae_q, ae_d;
  logic                  ce_q, ce_d;
  logic                  se_q, se_d;
  logic                  to_q, to_d;
  logic                  oor;

  addr_range_check #(
    .ADDR_W (BRAM_DEPTH),
    .EXP_W  (CNT_W)
  ) u_range (
    .base         (base_q),
    .exp          (exp_q),
    .addr         (wr.add_out),
    .out_of_range (oor)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    base_d  = base_q;
    wc_d    = wc_q;
    cs_d    = cs_q;
    cyc_d   = cyc_q;
    ae_d    = ae_q;
    ce_d    = ce_q;
    se_d    = se_q;
    to_d    = to_q;
    unique case (state_q)
      IDLE, DONE: begin
        // A start wins over a coincident stray write: the new job begins clean.
        if (wr.start) begin
          state_d = RUN;
          exp_d   = CNT_W'(wr.M) * CNT_W'(wr.K);
          base_d  = wr.base_addr_out;
          wc_d    = '0;
          cs_d    = '0;
          cyc_d   = '0;
          ae_d    = 1'b0;
          ce_d    = 1'b0;
          se_d    = 1'b0;
          to_d    = 1'b0;
        end else if (wr.w_out) begin
          se_d = 1'b1;
        end
      end
      RUN: begin
        if (cyc_q != '1) cyc_d = cyc_q + 1'b1;
        if (wr.w_out) begin
          if (wc_q != '1) wc_d = wc_q + 1'b1;
          cs_d = cs_q + wr.din_mem_out;
          if (oor) ae_d = 1'b1;
        end
        if (wr.done) begin
          state_d = DONE;
          ce_d    = (wc_d != exp_q);
        end else if (64'(cyc_d) >= 64'(TIMEOUT_CYCLES)) begin
          state_d = DONE;
          to_d    = 1'b1;
          ce_d    = (wc_d != exp_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      exp_q  <= '0;
      base_q <= '0;
      wc_q   <= '0;
      cs_q   <= '0;
      cyc_q  <= '0;
      ae_q   <= 1'b0;
      ce_q   <= 1'b0;
      se_q   <= 1'b0;
      to_q   <= 1'b0;
    end else begin
      exp_q  <= exp_d;
      base_q <= base_d;
      wc_q   <= wc_d;
      cs_q   <= cs_d;
      cyc_q  <= cyc_d;
      ae_q   <= ae_d;
      ce_q   <= ce_d;
      se_q   <= se_d;
      to_q   <= to_d;
    end
  end

  always_comb begin
    busy         = (state_q == RUN);
    result_valid = (state_q == DONE);
    write_count  = wc_q;
    checksum     = cs_q;
    cycle_count  = cyc_q;
    addr_err     = ae_q;
    count_err    = ce_q;
    stray_err    = se_q;
    timeout      = to_q;
  end
endmodule

// File: tb/tb_result_write_monitor.sv
// Directed bench: each job pushes its hand-computed status record; a monitor
// pops and compares whenever result_valid rises.
module tb_result_write_monitor;
  logic clk = 1'b0;
  logic rst;

  logic        busy, result_valid;
  logic [7:0]  write_count;
  logic [23:0] checksum;
  logic [23:0] cycle_count;
  logic        addr_err, count_err, stray_err, timeout;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0]  wc;
    logic [23:0] cs;
    logic [23:0] cyc;
    logic        ae;
    logic        ce;
    logic        to;
  } exp_t;

  exp_t        sb[$];
  logic [23:0] wdata[16];

  result_write_monitor_if #(.MAT_SIZE_BITS(4), .BRAM_DEPTH(10), .VAL_SIZE(24)) wr ();

  result_write_monitor #(
    .MAT_SIZE_BITS  (4),
    .BRAM_DEPTH     (10),
    .VAL_SIZE       (24),
    .CYC_W          (24),
    .TIMEOUT_CYCLES (20)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr           (wr),
    .busy         (busy),
    .result_valid (result_valid),
    .write_count  (write_count),
    .checksum     (checksum),
    .cycle_count  (cycle_count),
    .addr_err     (addr_err),
    .count_err    (count_err),
    .stray_err    (stray_err),
    .timeout      (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 'h%0h, required 'h%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard consumer.
  initial begin
    logic rv_prev = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (result_valid === 1'b1 && rv_prev !== 1'b1) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_result", 1, 0);
        end else begin
          e = sb.pop_front();
          check("write_count", write_count, e.wc);
          check("checksum",    checksum,    e.cs);
          check("cycle_count", cycle_count, e.cyc);
          check("addr_err",    addr_err,    e.ae);
          check("count_err",   count_err,   e.ce);
          check("stray_err",   stray_err,   0);
          check("timeout",     timeout,     e.to);
        end
      end
      rv_prev = result_valid;
    end
  end

  task automatic job(input logic [3:0] m, input logic [3:0] k, input logic [9:0] base,
                     input int nw, input bit bad_last, input int gap, input bit coinc,
                     input exp_t e);
    sb.push_back(e);
    wr.M = m; wr.K = k; wr.base_addr_out = base;
    wr.start = 1'b1;
    tick();
    wr.start = 1'b0;
    check("busy_after_start", busy, 1);
    check("rv_drop_after_start", result_valid, 0);
    check("stray_clear_on_start", stray_err, 0);
    for (int i = 0; i < nw; i++) begin
      wr.w_out       = 1'b1;
      wr.add_out     = (bad_last && i == nw - 1) ? base + 10'(m * k) : base + 10'(i);
      wr.din_mem_out = wdata[i];
      if (coinc && i == nw - 1) wr.done = 1'b1;
      tick();
    end
    wr.w_out = 1'b0;
    wr.done  = 1'b0;
    if (!coinc) begin
      repeat (gap) tick();
      wr.done = 1'b1;
      tick();
      wr.done = 1'b0;
    end
    check("rv_after_done", result_valid, 1);
    check("busy_after_done", busy, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},  busy, 0);
    check({tag, "_rv"},    result_valid, 0);
    check({tag, "_wc"},    write_count, 0);
    check({tag, "_cs"},    checksum, 0);
    check({tag, "_cyc"},   cycle_count, 0);
    check({tag, "_ae"},    addr_err, 0);
    check({tag, "_ce"},    count_err, 0);
    check({tag, "_se"},    stray_err, 0);
    check({tag, "_to"},    timeout, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) wdata[i] = 24'(i + 1);
    rst = 1'b1;
    wr.start = 1'b0; wr.M = '0; wr.K = '0; wr.base_addr_out = '0;
    wr.w_out = 1'b0; wr.add_out = '0; wr.din_mem_out = '0; wr.done = 1'b0;
    tick();
    tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    // Stray write in IDLE, then done in IDLE is ignored.
    wr.w_out = 1'b1; wr.add_out = 10'h010; wr.din_mem_out = 24'h5;
    tick();
    wr.w_out = 1'b0;
    check("stray_idle", stray_err, 1);
    wr.done = 1'b1;
    tick();
    wr.done = 1'b0;
    check("done_in_idle_ignored", result_valid, 0);

    // Clean 3x4 job: writes E1..E12, done at E15.
    job(4'd3, 4'd4, 10'h010, 12, 1'b0, 2, 1'b0,
        '{wc: 8'd12, cs: 24'd78, cyc: 24'd15, ae: 1'b0, ce: 1'b0, to: 1'b0});
    // Last write lands at 0x01C, one past the end.
    job(4'd3, 4'd4, 10'h010, 12, 1'b1, 2, 1'b0,
        '{wc: 8'd12, cs: 24'd78, cyc: 24'd15, ae: 1'b1, ce: 1'b0, to: 1'b0});
    // Only 11 writes.
    job(4'd3, 4'd4, 10'h010, 11, 1'b0, 2, 1'b0,
        '{wc: 8'd11, cs: 24'd66, cyc: 24'd14, ae: 1'b0, ce: 1'b1, to: 1'b0});

    // Stray write while DONE keeps result_valid.
    wr.w_out = 1'b1; wr.add_out = 10'h010; wr.din_mem_out = 24'h7;
    tick();
    wr.w_out = 1'b0;
    check("stray_done", stray_err, 1);
    check("stray_done_rv_held", result_valid, 1);
    check("stray_done_cs_held", checksum, 24'd66);

    // Last write coincident with done.
    job(4'd3, 4'd4, 10'h010, 12, 1'b0, 0, 1'b1,
        '{wc: 8'd12, cs: 24'd78, cyc: 24'd12, ae: 1'b0, ce: 1'b0, to: 1'b0});

    // Timeout at 20 cycles, with a start during RUN that must be ignored.
    sb.push_back('{wc: 8'd3, cs: 24'd6, cyc: 24'd20, ae: 1'b0, ce: 1'b1, to: 1'b1});
    wr.M = 4'd3; wr.K = 4'd4; wr.base_addr_out = 10'h010;
    wr.start = 1'b1;
    tick();
    wr.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wr.w_out = 1'b1; wr.add_out = 10'h010 + 10'(i); wr.din_mem_out = wdata[i];
      tick();
    end
    wr.w_out = 1'b0;
    wr.start = 1'b1;
    tick();
    wr.start = 1'b0;
    repeat (15) tick();
    check("busy_before_timeout", busy, 1);
    tick();
    check("busy_after_timeout", busy, 0);
    check("rv_after_timeout", result_valid, 1);

    // Checksum wrap: 0xFFFFFF + 0x000002.
    wdata[0] = 24'hFFFFFF;
    wdata[1] = 24'h000002;
    job(4'd1, 4'd2, 10'h100, 2, 1'b0, 0, 1'b0,
        '{wc: 8'd2, cs: 24'h000001, cyc: 24'd3, ae: 1'b0, ce: 1'b0, to: 1'b0});
    wdata[0] = 24'd1;
    wdata[1] = 24'd2;

    // M=0: any write is both out of range and a count error.
    job(4'd0, 4'd5, 10'h020, 1, 1'b0, 0, 1'b0,
        '{wc: 8'd1, cs: 24'd1, cyc: 24'd2, ae: 1'b1, ce: 1'b1, to: 1'b0});

    // Reset after 5 writes aborts with no residual status.
    wr.M = 4'd3; wr.K = 4'd4; wr.base_addr_out = 10'h010;
    wr.start = 1'b1;
    tick();
    wr.start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wr.w_out = 1'b1; wr.add_out = 10'h010 + 10'(i); wr.din_mem_out = wdata[i];
      tick();
    end
    wr.w_out = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_all_zero("midrun_reset");
    wr.done = 1'b1;
    tick();
    wr.done = 1'b0;
    check("done_after_reset_ignored", result_valid, 0);

    repeat (3) tick();
    check("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
